// File: rtl/huffman_decode.sv
`default_nettype none
// ============================================================================
//  Module   : huffman_decode
//  Purpose  : Table-driven Huffman bitstream decoder. Packs decoded bytes into
//             32-bit words, first symbol in the top byte.
//  Revision : 1.0  initial release
// ============================================================================
module huffman_decode #(
  parameter int MAX_LEN = 12,
  parameter int CNT_W   = 24
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               decode_start,
  input  logic [CNT_W-1:0]   sym_total,
  output logic               decode_done,
  output logic               decode_error,
  input  logic [31:0]        src_data,
  input  logic               src_valid,
  input  logic               src_empty,
  output logic               rd_src,
  output logic [MAX_LEN-1:0] dec_addr,
  input  logic [11:0]        dec_data,
  output logic [31:0]        out_data,
  output logic               out_wr,
  input  logic               out_full,
  output logic               out_last
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_DECODE = 3'd2,
    S_FLUSH  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [6:0] c_WORD_BITS = 7'd32;
  localparam logic [6:0] c_MAX_LEN   = 7'(MAX_LEN);

  state_t             r_state;
  logic [63:0]        r_bbuf;
  logic [6:0]         r_bit_cnt;
  logic               r_rd_pend;
  logic [1:0]         r_lane;
  logic [CNT_W-1:0]   r_sym_cnt;
  logic [CNT_W-1:0]   r_sym_total;
  logic [31:0]        r_pack;
  logic [31:0]        r_out_data;
  logic               r_out_wr;
  logic               r_out_last;
  logic               r_done;
  logic               r_error;

  logic [3:0]         w_len;
  logic [7:0]         w_sym;
  logic               w_active;
  logic               w_rd_req;
  logic               w_refill;
  logic               w_len_ok;
  logic               w_stall;
  logic               w_consume;
  logic               w_last_sym;
  logic               w_lookup_go;
  logic [6:0]         w_use_len;
  logic [6:0]         w_cnt_after;
  logic [6:0]         w_cnt_next;
  logic [63:0]        w_merge;
  logic [63:0]        w_bbuf_next;
  logic [31:0]        w_pack_next;

  assign w_len       = dec_data[11:8];
  assign w_sym       = dec_data[7:0];
  assign w_active    = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_rd_req    = w_active && !src_empty && (r_bit_cnt <= c_WORD_BITS) && !r_rd_pend;
  assign w_refill    = src_valid && r_rd_pend;
  assign w_len_ok    = (w_len != 4'd0) && ({3'b000, w_len} <= r_bit_cnt);
  assign w_stall     = (r_lane == 2'd3) && out_full;
  assign w_consume   = (r_state == S_DECODE) && w_len_ok && !w_stall;
  assign w_last_sym  = (r_sym_cnt + CNT_W'(1)) == r_sym_total;
  // Tail decode relies on zero padding below the last valid bit.
  assign w_lookup_go = (r_bit_cnt >= c_MAX_LEN) ||
                       ((r_bit_cnt != 7'd0) && src_empty && !r_rd_pend);

  // Shift out the consumed code and append a refill word below what remains.
  assign w_use_len   = w_consume ? {3'b000, w_len} : 7'd0;
  assign w_cnt_after = r_bit_cnt - w_use_len;
  assign w_merge     = w_refill ? ({src_data, 32'h0} >> w_cnt_after) : 64'h0;
  assign w_bbuf_next = (r_bbuf << w_use_len) | w_merge;
  assign w_cnt_next  = w_cnt_after + (w_refill ? c_WORD_BITS : 7'd0);
  assign w_pack_next = r_pack | ({w_sym, 24'h0} >> {r_lane, 3'b000});

  assign rd_src       = w_rd_req;
  assign dec_addr     = r_bbuf[63 -: MAX_LEN];
  assign out_data     = r_out_data;
  assign out_wr       = r_out_wr;
  assign out_last     = r_out_last;
  assign decode_done  = r_done;
  assign decode_error = r_error;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= S_IDLE;
      r_bbuf      <= 64'h0;
      r_bit_cnt   <= 7'd0;
      r_rd_pend   <= 1'b0;
      r_lane      <= 2'd0;
      r_sym_cnt   <= '0;
      r_sym_total <= '0;
      r_pack      <= 32'h0;
      r_out_data  <= 32'h0;
      r_out_wr    <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_out_wr   <= 1'b0;
      r_out_last <= 1'b0;
      r_done     <= 1'b0;

      if (w_rd_req) begin
        r_rd_pend <= 1'b1;
      end else if (w_refill) begin
        r_rd_pend <= 1'b0;
      end

      if (r_state != S_IDLE) begin
        r_bbuf    <= w_bbuf_next;
        r_bit_cnt <= w_cnt_next;
      end

      case (r_state)
        S_IDLE: begin
          if (decode_start) begin
            r_sym_total <= sym_total;
            r_bbuf      <= 64'h0;
            r_bit_cnt   <= 7'd0;
            r_rd_pend   <= 1'b0;
            r_lane      <= 2'd0;
            r_sym_cnt   <= '0;
            r_pack      <= 32'h0;
            r_error     <= 1'b0;
            r_state     <= (sym_total == '0) ? S_DONE : S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          if (w_lookup_go) begin
            r_state <= S_DECODE;
          end
        end

        S_DECODE: begin
          if (w_len == 4'd0) begin
            r_error <= 1'b1;
            r_state <= S_DONE;
          end else if (!w_len_ok) begin
            r_state <= S_LOOKUP;
          end else if (!w_stall) begin
            r_lane    <= r_lane + 2'd1;
            r_sym_cnt <= r_sym_cnt + CNT_W'(1);
            if (r_lane == 2'd3) begin
              r_out_data <= w_pack_next;
              r_out_wr   <= 1'b1;
              r_out_last <= w_last_sym;
              r_pack     <= 32'h0;
            end else begin
              r_pack <= w_pack_next;
            end
            r_state <= w_last_sym ? S_FLUSH : S_LOOKUP;
          end
        end

        S_FLUSH: begin
          // A job ending on a full word already flagged it as last.
          if (r_lane == 2'd0) begin
            r_state <= S_DONE;
          end else if (!out_full) begin
            r_out_data <= r_pack;
            r_out_wr   <= 1'b1;
            r_out_last <= 1'b1;
            r_lane     <= 2'd0;
            r_pack     <= 32'h0;
            r_state    <= S_DONE;
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_huffman_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_huffman_decode
//  Purpose  : Directed self-checking bench for huffman_decode.
//  Revision : 1.0  initial release
// ============================================================================
module tb_huffman_decode;

  logic        clk;
  logic        rstN;
  logic        decode_start;
  logic [23:0] sym_total;
  logic        decode_done;
  logic        decode_error;
  logic [31:0] src_data;
  logic        src_valid;
  logic        src_empty;
  logic        rd_src;
  logic [11:0] dec_addr;
  logic [11:0] dec_data;
  logic [31:0] out_data;
  logic        out_wr;
  logic        out_full;
  logic        out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] fmem [0:63];
  int          f_wr = 0;
  int          f_rd = 0;
  logic        err_mode = 1'b0;

  logic [31:0] wr_word [0:63];
  logic        wr_last [0:63];
  int          wr_n = 0;
  int          rd_n = 0;

  huffman_decode #(.MAX_LEN(12), .CNT_W(24)) dut (
    .clk          (clk),
    .rstN         (rstN),
    .decode_start (decode_start),
    .sym_total    (sym_total),
    .decode_done  (decode_done),
    .decode_error (decode_error),
    .src_data     (src_data),
    .src_valid    (src_valid),
    .src_empty    (src_empty),
    .rd_src       (rd_src),
    .dec_addr     (dec_addr),
    .dec_data     (dec_data),
    .out_data     (out_data),
    .out_wr       (out_wr),
    .out_full     (out_full),
    .out_last     (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Input FIFO model: data valid one cycle after the read strobe.
  assign src_empty = (f_rd == f_wr);
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      src_valid <= 1'b0;
      src_data  <= 32'h0;
    end else begin
      src_valid <= 1'b0;
      if (rd_src && (f_rd != f_wr)) begin
        src_data  <= fmem[f_rd];
        src_valid <= 1'b1;
        f_rd      <= f_rd + 1;
      end
    end
  end

  function automatic logic [11:0] tbl(input logic [11:0] a, input logic err);
    if (!a[11])            return {4'd1, 8'h41};
    else if (a[11:10] == 2'b10) return {4'd2, 8'h42};
    else if (err)          return 12'h000;
    else                   return {4'd2, 8'h43};
  endfunction

  always @(posedge clk) dec_data <= tbl(dec_addr, err_mode);

  always @(posedge clk) begin
    if (out_wr && wr_n < 64) begin
      wr_word[wr_n] <= out_data;
      wr_last[wr_n] <= out_last;
      wr_n          <= wr_n + 1;
    end
    if (rd_src) rd_n <= rd_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    fmem[f_wr] = w;
    f_wr = f_wr + 1;
  endtask

  task automatic start_job(input logic [23:0] n);
    @(negedge clk);
    decode_start = 1'b1;
    sym_total    = n;
    @(negedge clk);
    decode_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (decode_done) seen = 1'b1;
    end
    check(tag, {63'h0, seen}, 64'h1);
  endtask

  int wr0;
  int rd0;

  initial begin
    rstN         = 1'b0;
    decode_start = 1'b0;
    sym_total    = 24'h0;
    out_full     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rd_src", {63'h0, rd_src}, 64'h0);
    check("rst_out_wr", {63'h0, out_wr}, 64'h0);
    check("rst_out_last", {63'h0, out_last}, 64'h0);
    check("rst_out_data", {32'h0, out_data}, 64'h0);
    check("rst_done", {63'h0, decode_done}, 64'h0);
    check("rst_error", {63'h0, decode_error}, 64'h0);
    check("rst_dec_addr", {52'h0, dec_addr}, 64'h0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Four symbols fill exactly one word.
    wr0 = wr_n; rd0 = rd_n;
    push(32'h2C000000);
    start_job(24'd4);
    wait_done("t1_done", 200);
    check("t1_nwr", 64'(wr_n - wr0), 64'd1);
    check("t1_word", {32'h0, wr_word[wr0]}, 64'h41414243);
    check("t1_last", {63'h0, wr_last[wr0]}, 64'h1);
    check("t1_bitcnt", {57'h0, dut.r_bit_cnt}, 64'd26);
    check("t1_nrd", 64'(rd_n - rd0), 64'd1);
    check("t1_err", {63'h0, decode_error}, 64'h0);
    @(negedge clk);
    check("t1_done_pulse", {63'h0, decode_done}, 64'h0);

    // Six symbols: one full word then a partial flushed word.
    wr0 = wr_n;
    push(32'h2C000000);
    start_job(24'd6);
    wait_done("t2_done", 200);
    check("t2_nwr", 64'(wr_n - wr0), 64'd2);
    check("t2_word0", {32'h0, wr_word[wr0]}, 64'h41414243);
    check("t2_last0", {63'h0, wr_last[wr0]}, 64'h0);
    check("t2_word1", {32'h0, wr_word[wr0+1]}, 64'h41410000);
    check("t2_last1", {63'h0, wr_last[wr0+1]}, 64'h1);

    // Code '11' split across the word boundary.
    wr0 = wr_n;
    push(32'h00000001);
    push(32'h80000000);
    start_job(24'd32);
    wait_done("t3_done", 400);
    check("t3_nwr", 64'(wr_n - wr0), 64'd8);
    check("t3_word0", {32'h0, wr_word[wr0]}, 64'h41414141);
    check("t3_word6", {32'h0, wr_word[wr0+6]}, 64'h41414141);
    check("t3_word7", {32'h0, wr_word[wr0+7]}, 64'h41414143);
    check("t3_last7", {63'h0, wr_last[wr0+7]}, 64'h1);

    // Output full held across the lane-3 decode.
    wr0 = wr_n;
    push(32'h2C000000);
    out_full = 1'b1;
    start_job(24'd4);
    repeat (25) @(negedge clk);
    check("t4_stall_nwr", 64'(wr_n - wr0), 64'd0);
    check("t4_stall_bitcnt", {57'h0, dut.r_bit_cnt}, 64'd28);
    out_full = 1'b0;
    @(negedge clk);
    check("t4_wr", {63'h0, out_wr}, 64'h1);
    check("t4_word", {32'h0, out_data}, 64'h41414243);
    check("t4_last", {63'h0, out_last}, 64'h1);
    wait_done("t4_done", 50);

    // Invalid entry on the third symbol.
    wr0 = wr_n;
    err_mode = 1'b1;
    push(32'h30000000);
    start_job(24'd8);
    wait_done("t5_done", 200);
    check("t5_err", {63'h0, decode_error}, 64'h1);
    check("t5_nwr", 64'(wr_n - wr0), 64'd0);
    err_mode = 1'b0;
    @(negedge clk);
    check("t5_err_held", {63'h0, decode_error}, 64'h1);

    // Zero-length job clears the error flag.
    start_job(24'd0);
    check("t6_err_clr", {63'h0, decode_error}, 64'h0);
    @(negedge clk);
    check("t6_done", {63'h0, decode_done}, 64'h1);

    // Reset mid-job, then a zero-length job.
    for (int i = 0; i < 4; i++) push(32'h00000000);
    start_job(24'd100);
    repeat (10) @(negedge clk);
    rstN = 1'b0;
    #1;
    check("t7_rst_rd", {63'h0, rd_src}, 64'h0);
    check("t7_rst_wr", {63'h0, out_wr}, 64'h0);
    f_wr = f_rd;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    wr0 = wr_n; rd0 = rd_n;
    start_job(24'd0);
    check("t7_done_early", {63'h0, decode_done}, 64'h0);
    @(negedge clk);
    check("t7_done", {63'h0, decode_done}, 64'h1);
    @(negedge clk);
    check("t7_nrd", 64'(rd_n - rd0), 64'd0);
    check("t7_nwr", 64'(wr_n - wr0), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/huffman_decode.md
# huffman_decode

Huffman bitstream decoder, the receive-side counterpart of the 4-lane VLC encoder. It reads MSB-first packed 32-bit code words from an input FIFO and resolves each code through an external 4096-entry decode table (one lookup per symbol). It repacks the decoded bytes four per 32-bit word into an output FIFO and stops after a programmed symbol count. It sits between the compressed-data FIFO and the downstream LZ4 decompression path.

## Interface
Parameters:
- MAX_LEN, 12, longest code length in bits; also the decode table address width.
- CNT_W, 24, width of the symbol counter.

Ports:
- clk  in  1  clock.
- rstN  in  1  asynchronous, active-low reset.
- decode_start  in  1  one-cycle start pulse; ignored unless the block is in IDLE.
- sym_total  in  CNT_W  number of symbols to decode; sampled on decode_start.
- decode_done  out  1  one-cycle pulse at end of job (normal or error).
- decode_error  out  1  set on an invalid table entry; held until the next decode_start.
- src_data  in  32  bitstream word; bit 31 is the first bit in stream order.
- src_valid  in  1  src_data is valid; arrives 1 cycle after rd_src.
- src_empty  in  1  input FIFO is empty.
- rd_src  out  1  input FIFO read strobe.
- dec_addr  out  MAX_LEN  decode table address = next MAX_LEN stream bits.
- dec_data  in  12  synchronous table read data {len[3:0], sym[7:0]}, 1-cycle latency; len 0 marks an invalid entry.
- out_data  out  32  packed symbols; first symbol in [31:24].
- out_wr  out  1  output FIFO write strobe.
- out_full  in  1  output FIFO full.
- out_last  out  1  asserted together with out_wr on the final word of a job.

## Operation
- Bit buffer: 64-bit left-aligned shift register `bbuf`; bbuf[63] is the next stream bit. bit_cnt (7 bits, 0..64) counts valid bits. Invalid bits are held at 0.
- dec_addr = bbuf[63:64-MAX_LEN] (combinational from the register).
- Refill runs concurrently with decode:
  - rd_src pulses when state≠IDLE/DONE, !src_empty, bit_cnt ≤ 32, and no read is outstanding.
  - At most 1 read is outstanding. It clears when src_valid arrives.
  - On src_valid the word is ORed in at position (post-consume bit_cnt): bbuf |= src_data << (32 − cnt').
- Consume: shifting left by len and appending in the same cycle is legal; new bit_cnt = bit_cnt − len + 32.
- FSM states: IDLE, LOOKUP, DECODE, FLUSH, DONE.
  - IDLE: on decode_start, latch sym_total, clear bbuf/bit_cnt/lane/counter/decode_error. Go to DONE if sym_total=0, else LOOKUP.
  - LOOKUP: proceed to DECODE when bit_cnt ≥ MAX_LEN, or when bit_cnt ≥ 1 and src_empty and no read is outstanding (tail decode with zero padding). Otherwise wait.
  - DECODE (dec_data valid):
    - len=0: set decode_error and go to DONE. No output write for the partial word.
    - len > bit_cnt: no consume; return to LOOKUP to wait for more data.
    - Lane 3 to be filled and out_full: stall in DECODE with no consume.
    - Otherwise: consume len bits, place sym in lane (lane 0 → [31:24]), lane++, sym_cnt++. If lane wraps from 3, assert out_wr next cycle.
    - Exit: if sym_cnt reaches sym_total, go to FLUSH; else go to LOOKUP.
  - FLUSH: if lane≠0, wait for !out_full, then write the partial word (unused lanes 0) with out_last=1. If lane=0, the final full word was already written with out_last=1. Then go to DONE.
  - DONE: pulse decode_done for 1 cycle, go to IDLE. Leftover bbuf bits are discarded.
- Reset mid-job aborts immediately. Any read in flight is lost; the input FIFO must be reset with the block.

## Timing
- Reset values: rd_src 0, out_wr 0, out_last 0, out_data 0, decode_done 0, decode_error 0, dec_addr 0, state IDLE.
- Throughput: 1 symbol per 2 cycles (LOOKUP + DECODE) with a full buffer and output not full.
- First dec_addr lookup occurs ≥3 cycles after decode_start (read, data, LOOKUP).
- out_wr is registered: it asserts 1 cycle after the DECODE that fills lane 3, and is 1 cycle wide.
- out_full is sampled only in DECODE (lane 3) and FLUSH. Words are never dropped.
- Max output FIFO overrun is 0 words.

## Test plan
- Table: addr[11]=0 → {1,0x41}; addr[11:10]=10 → {2,0x42}; 11 → {2,0x43}. Stream 0x2C000000, sym_total=4 → one write 0x41414243 with out_last=1, then decode_done; bit_cnt ends at 26.
- Same table, sym_total=6, stream 0x2C000000 → writes 0x41414243, then 0x41410000 (out_last=1).
- Code straddling a word boundary: 0x00000001 followed by 0x80000000 with 0x43 code '11' at bits 0/31 → 31×0x41 then 0x43 decoded correctly.
- Hold out_full=1 across the lane-3 DECODE for 10 cycles → no consume, no write; the word is written 1 cycle after release.
- Table entry len=0 hit on the 3rd symbol → decode_error=1, decode_done pulse, no out_wr.
- Assert rstN=0 mid-job, then start a new job with sym_total=0 → decode_done 2 cycles after start, no rd_src, no out_wr.
